// File: rtl/oi_cmd_sequencer_pkg.sv
// Shared definitions for the iRobot Open Interface command sequencer.
// Contents: FSM state codes, OI opcodes, the controller state enum, and the
// packet-content and packet-length functions. The sequencer builds its packets
// from these functions byte by byte, so no packet ROM is needed.
package oi_cmd_sequencer_pkg;

    // State codes driven by the figure-8 FSM. Codes 5-7 are not valid.
    localparam logic [2:0] ST_STOP       = 3'd0;
    localparam logic [2:0] ST_CLKWISE    = 3'd1;
    localparam logic [2:0] ST_CNTCLKWISE = 3'd2;
    localparam logic [2:0] ST_INIT       = 3'd3;
    localparam logic [2:0] ST_SONGINIT   = 3'd4;

    // OI opcodes
    localparam logic [7:0] OP_START = 8'd128;
    localparam logic [7:0] OP_FULL  = 8'd132;
    localparam logic [7:0] OP_DRIVE = 8'd137;
    localparam logic [7:0] OP_SONG  = 8'd140;
    localparam logic [7:0] OP_PLAY  = 8'd141;

    localparam int unsigned MAX_PKT_LEN = 7;
    localparam int unsigned IDX_W       = $clog2(MAX_PKT_LEN);

    typedef enum logic [1:0] {
        CTRL_IDLE = 2'd0,
        CTRL_SEND = 2'd1,
        CTRL_LAP  = 2'd2
    } ctrl_e;

    // Number of bytes in the packet for a state code; 0 means no packet.
    function automatic logic [IDX_W-1:0] pkt_len(input logic [2:0] code);
        logic [IDX_W-1:0] len;
        case (code)
            ST_STOP:       len = IDX_W'(5);
            ST_CLKWISE:    len = IDX_W'(5);
            ST_CNTCLKWISE: len = IDX_W'(5);
            ST_INIT:       len = IDX_W'(2);
            ST_SONGINIT:   len = IDX_W'(7);
            default:       len = IDX_W'(0);
        endcase
        return len;
    endfunction

    // Byte 'idx' (0 = first on the wire) of the packet for a state code.
    // Drive packets carry velocity then radius, MSB first; clockwise turns
    // use the negated radius.
    function automatic logic [7:0] pkt_byte(input logic [2:0]       code,
                                            input logic [IDX_W-1:0] idx,
                                            input logic [15:0]      vel,
                                            input logic [15:0]      rad);
        logic [7:0]  b;
        logic [15:0] turn;
        turn = (code == ST_CLKWISE) ? (16'd0 - rad) : rad;
        b    = 8'd0;
        case (code)
            ST_STOP: begin
                case (idx)
                    IDX_W'(0): b = OP_DRIVE;
                    default:   b = 8'd0;
                endcase
            end
            ST_CLKWISE, ST_CNTCLKWISE: begin
                case (idx)
                    IDX_W'(0): b = OP_DRIVE;
                    IDX_W'(1): b = vel[15:8];
                    IDX_W'(2): b = vel[7:0];
                    IDX_W'(3): b = turn[15:8];
                    IDX_W'(4): b = turn[7:0];
                    default:   b = 8'd0;
                endcase
            end
            ST_INIT: begin
                case (idx)
                    IDX_W'(0): b = OP_START;
                    IDX_W'(1): b = OP_FULL;
                    default:   b = 8'd0;
                endcase
            end
            ST_SONGINIT: begin
                // define song 0 as one note (72, 16/64 s), then play song 0
                case (idx)
                    IDX_W'(0): b = OP_SONG;
                    IDX_W'(1): b = 8'd0;
                    IDX_W'(2): b = 8'd1;
                    IDX_W'(3): b = 8'd72;
                    IDX_W'(4): b = 8'd16;
                    IDX_W'(5): b = OP_PLAY;
                    IDX_W'(6): b = 8'd0;
                    default:   b = 8'd0;
                endcase
            end
            default: b = 8'd0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/oi_cmd_sequencer_lap_timer.sv
// Lap timer for the OI command sequencer.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : abandon any lap in progress (dominates start)
//   start    : begin a lap; done pulses LAP_CYCLES clocks after this cycle's edge
//   done     : registered one-cycle pulse when the lap completes
module oi_cmd_sequencer_lap_timer #(
    parameter logic [31:0] LAP_CYCLES = 32'd50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic start,
    output logic done
);

    logic        run_q,   run_d;
    logic [31:0] count_q, count_d;
    logic        done_q,  done_d;

    // Timer state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q   <= 1'b0;
            count_q <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            run_q   <= run_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    // Count from 0 at the start edge; the edge that sees LAP_CYCLES-1 raises done
    always_comb begin
        run_d   = run_q;
        count_d = count_q;
        done_d  = 1'b0;
        if (clr) begin
            run_d   = 1'b0;
            count_d = 32'd0;
        end else if (start) begin
            run_d   = 1'b1;
            count_d = 32'd0;
        end else if (run_q) begin
            if (count_q == (LAP_CYCLES - 32'd1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end else begin
                count_d = count_q + 32'd1;
            end
        end else begin
            count_d = count_q;
        end
    end

    assign done = done_q;

endmodule

// File: rtl/oi_cmd_sequencer.sv
// OI command sequencer: turns the figure-8 FSM state code into OI command
// packets streamed byte-serially over a valid/ready link to the UART TX, and
// times each drive lap, returning a one-cycle 'enables' pulse to the FSM.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   state     : FSM state code (0-4 valid)
//   tx_data   : command byte, held stable while tx_valid & !tx_ready
//   tx_valid  : tx_data valid
//   tx_ready  : UART TX accepts the byte at a posedge with tx_valid high
//   enables   : one-cycle lap-complete pulse
//   busy      : a byte is being offered or a new packet is waiting behind a stall
module oi_cmd_sequencer
    import oi_cmd_sequencer_pkg::*;
#(
    parameter logic [31:0]        LAP_CYCLES = 32'd50_000_000,
    parameter logic signed [15:0] VELOCITY   = 16'sd200,
    parameter logic signed [15:0] RADIUS     = 16'sd500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] state,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       enables,
    output logic       busy
);

    ctrl_e            ctrl_q, ctrl_d;
    logic [2:0]       state_q;
    logic [IDX_W-1:0] idx_q,      idx_d;
    logic [7:0]       tx_data_q,  tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             pending_q,  pending_d;
    logic             busy_q;

    logic             change_s, stalled_s, accept_s, load_s;
    logic             new_valid_s, last_s, is_drive_s;
    logic             timer_clr_s, timer_start_s, lap_done_s;
    logic [IDX_W-1:0] cur_len_s;

    // Handshake and packet bookkeeping shared by next-state and output logic
    always_comb begin
        change_s    = (state != state_q);
        stalled_s   = tx_valid_q & ~tx_ready;
        accept_s    = tx_valid_q & tx_ready;
        // A new packet starts on a change unless a byte is stalled; a change
        // seen during a stall is remembered and taken when that byte goes.
        load_s      = (change_s & ~stalled_s) | (pending_q & accept_s);
        new_valid_s = (pkt_len(state) != IDX_W'(0));
        cur_len_s   = pkt_len(state_q);
        last_s      = accept_s & ((idx_q + IDX_W'(1)) == cur_len_s);
        is_drive_s  = (state_q == ST_CLKWISE) | (state_q == ST_CNTCLKWISE);
    end

    // State register: controller state and all datapath flops
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q     <= CTRL_IDLE;
            state_q    <= 3'b111;     // sentinel: any valid code looks like a change
            idx_q      <= IDX_W'(0);
            tx_data_q  <= 8'd0;
            tx_valid_q <= 1'b0;
            pending_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            state_q    <= state;
            idx_q      <= idx_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            pending_q  <= pending_d;
            busy_q     <= tx_valid_d | pending_d;
        end
    end

    // Next-state logic for the controller
    always_comb begin
        ctrl_d = ctrl_q;
        if (load_s) begin
            ctrl_d = new_valid_s ? CTRL_SEND : CTRL_IDLE;
        end else begin
            case (ctrl_q)
                CTRL_IDLE: ctrl_d = CTRL_IDLE;
                CTRL_SEND: begin
                    if (last_s) begin
                        ctrl_d = is_drive_s ? CTRL_LAP : CTRL_IDLE;
                    end else begin
                        ctrl_d = CTRL_SEND;
                    end
                end
                CTRL_LAP: begin
                    if (lap_done_s) begin
                        ctrl_d = CTRL_IDLE;
                    end else begin
                        ctrl_d = CTRL_LAP;
                    end
                end
                default: ctrl_d = CTRL_IDLE;
            endcase
        end
    end

    // Output/datapath logic: byte stepping, pending flag, timer control
    always_comb begin
        idx_d         = idx_q;
        tx_data_d     = tx_data_q;
        tx_valid_d    = tx_valid_q;
        pending_d     = pending_q;
        timer_clr_s   = 1'b0;
        timer_start_s = 1'b0;
        if (load_s) begin
            // Remainder of any old packet is dropped; 'state' is the latest code
            idx_d       = IDX_W'(0);
            tx_valid_d  = new_valid_s;
            tx_data_d   = new_valid_s ? pkt_byte(state, IDX_W'(0), VELOCITY, RADIUS) : 8'd0;
            pending_d   = 1'b0;
            timer_clr_s = 1'b1;
        end else if (change_s) begin
            // Only reachable while a byte is stalled
            pending_d = 1'b1;
        end else if (accept_s) begin
            if (last_s) begin
                idx_d         = IDX_W'(0);
                tx_valid_d    = 1'b0;
                timer_start_s = is_drive_s;
            end else begin
                idx_d     = idx_q + IDX_W'(1);
                tx_data_d = pkt_byte(state_q, idx_q + IDX_W'(1), VELOCITY, RADIUS);
            end
        end else begin
            idx_d = idx_q;
        end
    end

    oi_cmd_sequencer_lap_timer #(
        .LAP_CYCLES (LAP_CYCLES)
    ) u_lap_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (timer_clr_s),
        .start (timer_start_s),
        .done  (lap_done_s)
    );

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign busy     = busy_q;
    assign enables  = lap_done_s;

endmodule

// File: tb/tb_oi_cmd_sequencer.sv
module tb_oi_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] state;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       enables;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int en_cnt = 0;
    int en_last_cyc = 0;

    logic [7:0] got [0:15];
    int         got_cyc [0:15];
    int         got_n;
    logic       timed_out;

    oi_cmd_sequencer #(
        .LAP_CYCLES (32'd10),
        .VELOCITY   (16'sd200),
        .RADIUS     (16'sd500)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .state    (state),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .enables  (enables),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (enables === 1'b1) begin
            en_cnt      = en_cnt + 1;
            en_last_cyc = cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Records every byte accepted until tx_valid drops after the first one
    task automatic collect(input int budget);
        got_n     = 0;
        timed_out = 1'b0;
        for (int c = 0; c <= budget; c++) begin
            if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
                if (got_n < 16) begin
                    got[got_n]     = tx_data;
                    got_cyc[got_n] = cyc;
                end
                got_n = got_n + 1;
            end else if (tx_valid !== 1'b1 && got_n > 0) begin
                return;
            end
            tick();
        end
        timed_out = 1'b1;
    endtask

    task automatic test_reset();
        logic [7:0] exp [0:4];
        exp = '{8'd137, 8'd0, 8'd0, 8'd0, 8'd0};
        rst = 1'b1; state = 3'd0; tx_ready = 1'b1;
        tick(); tick(); tick();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", tx_valid); end
        checks++; if (tx_data !== 8'd0) begin errors++; $display("FAIL reset_data: got %0d expected 0", tx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (enables !== 1'b0) begin errors++; $display("FAIL reset_enables: got %b expected 0", enables); end
        en_cnt = 0;
        rst = 1'b0;
        tick();
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'd137) begin errors++; $display("FAIL stop_first_byte: got valid=%b data=%0d expected valid=1 data=137", tx_valid, tx_data); end
        collect(20);
        checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL stop_timeout: got timeout expected packet end"); end
        checks++; if (got_n !== 5) begin errors++; $display("FAIL stop_len: got %0d expected 5", got_n); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL stop_byte%0d: got %0d expected %0d", i, got[i], exp[i]); end
            checks++; if (got_cyc[i] !== got_cyc[0] + i) begin errors++; $display("FAIL stop_b2b%0d: got cycle %0d expected %0d", i, got_cyc[i], got_cyc[0] + i); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy_after: got %b expected 0", busy); end
        repeat (15) tick();
        checks++; if (en_cnt !== 0) begin errors++; $display("FAIL stop_enables: got %0d pulses expected 0", en_cnt); end
    endtask

    task automatic test_init_song();
        logic [7:0] exp_init [0:1];
        logic [7:0] exp_song [0:6];
        exp_init = '{8'd128, 8'd132};
        exp_song = '{8'd140, 8'd0, 8'd1, 8'd72, 8'd16, 8'd141, 8'd0};
        state = 3'd3;
        collect(20);
        checks++; if (got_n !== 2) begin errors++; $display("FAIL init_len: got %0d expected 2", got_n); end
        for (int i = 0; i < 2; i++) begin
            checks++; if (got[i] !== exp_init[i]) begin errors++; $display("FAIL init_byte%0d: got %0d expected %0d", i, got[i], exp_init[i]); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL init_busy_after: got %b expected 0", busy); end
        state = 3'd4;
        collect(20);
        checks++; if (got_n !== 7) begin errors++; $display("FAIL song_len: got %0d expected 7", got_n); end
        for (int i = 0; i < 7; i++) begin
            checks++; if (got[i] !== exp_song[i]) begin errors++; $display("FAIL song_byte%0d: got %0d expected %0d", i, got[i], exp_song[i]); end
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL song_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_lap();
        logic [7:0] exp_cw [0:4];
        logic [7:0] exp_ccw [0:4];
        int last;
        exp_cw  = '{8'd137, 8'h00, 8'hC8, 8'hFE, 8'h0C};
        exp_ccw = '{8'd137, 8'h00, 8'hC8, 8'h01, 8'hF4};
        for (int pass = 0; pass < 2; pass++) begin
            en_cnt = 0;
            state = (pass == 0) ? 3'd1 : 3'd2;
            collect(20);
            checks++; if (got_n !== 5) begin errors++; $display("FAIL lap%0d_len: got %0d expected 5", pass, got_n); end
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (got[i] !== ((pass == 0) ? exp_cw[i] : exp_ccw[i])) begin
                    errors++;
                    $display("FAIL lap%0d_byte%0d: got %0h expected %0h", pass, i, got[i], (pass == 0) ? exp_cw[i] : exp_ccw[i]);
                end
            end
            last = got_cyc[4];
            repeat (30) tick();
            checks++; if (en_cnt !== 1) begin errors++; $display("FAIL lap%0d_pulses: got %0d expected 1", pass, en_cnt); end
            checks++; if (en_last_cyc !== last + 11) begin errors++; $display("FAIL lap%0d_timing: got cycle %0d expected %0d", pass, en_last_cyc, last + 11); end
        end
    endtask

    task automatic test_stall();
        logic [7:0] exp [0:4];
        exp = '{8'd1, 8'd72, 8'd16, 8'd141, 8'd0};
        state = 3'd4;
        tick();
        checks++; if (tx_data !== 8'd140) begin errors++; $display("FAIL stall_b0: got %0d expected 140", tx_data); end
        tick();
        checks++; if (tx_data !== 8'd0) begin errors++; $display("FAIL stall_b1: got %0d expected 0", tx_data); end
        tick();
        checks++; if (tx_data !== 8'd1) begin errors++; $display("FAIL stall_b2: got %0d expected 1", tx_data); end
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== 8'd1) begin
                errors++;
                $display("FAIL stall_hold%0d: got valid=%b data=%0d expected valid=1 data=1", i, tx_valid, tx_data);
            end
        end
        tx_ready = 1'b1;
        collect(20);
        checks++; if (got_n !== 5) begin errors++; $display("FAIL stall_rest_len: got %0d expected 5", got_n); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL stall_rest%0d: got %0d expected %0d", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_change_while_stalled();
        logic [7:0] exp [0:5];
        exp = '{8'hC8, 8'd137, 8'd0, 8'd0, 8'd0, 8'd0};
        en_cnt = 0;
        state = 3'd2;
        tick(); tick(); tick();
        checks++; if (tx_data !== 8'hC8) begin errors++; $display("FAIL chg_b2: got %0h expected c8", tx_data); end
        tx_ready = 1'b0;
        tick();
        state = 3'd0;
        tick();
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hC8) begin errors++; $display("FAIL chg_hold: got valid=%b data=%0h expected valid=1 data=c8", tx_valid, tx_data); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL chg_busy: got %b expected 1", busy); end
        tick();
        checks++; if (tx_data !== 8'hC8) begin errors++; $display("FAIL chg_hold2: got %0h expected c8", tx_data); end
        tx_ready = 1'b1;
        collect(20);
        checks++; if (got_n !== 6) begin errors++; $display("FAIL chg_len: got %0d expected 6", got_n); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL chg_byte%0d: got %0d expected %0d", i, got[i], exp[i]); end
        end
        repeat (30) tick();
        checks++; if (en_cnt !== 0) begin errors++; $display("FAIL chg_enables: got %0d pulses expected 0", en_cnt); end
    endtask

    task automatic test_reset_mid_packet();
        logic [7:0] exp [0:6];
        exp = '{8'd140, 8'd0, 8'd1, 8'd72, 8'd16, 8'd141, 8'd0};
        state = 3'd4;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        checks++; if (tx_valid !== 1'b0 || tx_data !== 8'd0) begin errors++; $display("FAIL rstmid_out: got valid=%b data=%0d expected valid=0 data=0", tx_valid, tx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        rst = 1'b0;
        tick();
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'd140) begin errors++; $display("FAIL rstmid_restart: got valid=%b data=%0d expected valid=1 data=140", tx_valid, tx_data); end
        collect(20);
        checks++; if (got_n !== 7) begin errors++; $display("FAIL rstmid_len: got %0d expected 7", got_n); end
        for (int i = 0; i < 7; i++) begin
            checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL rstmid_byte%0d: got %0d expected %0d", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_invalid_code();
        state = 3'd5;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (tx_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL invalid%0d: got valid=%b busy=%b expected 0 0", i, tx_valid, busy);
            end
        end
        state = 3'd0;
        collect(20);
        checks++; if (got_n !== 5 || got[0] !== 8'd137) begin errors++; $display("FAIL invalid_recover: got len=%0d b0=%0d expected len=5 b0=137", got_n, got[0]); end
    endtask

    initial begin
        test_reset();
        test_init_song();
        test_lap();
        test_stall();
        test_change_while_stalled();
        test_reset_mid_packet();
        test_invalid_code();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
